// File: rtl/count_step_checker_pkg.sv
// Shared types and widths for the count step checker.
package count_chk_pkg;

  localparam int COUNT_W    = 3;
  localparam int WRAP_CNT_W = 8;
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_e;

  // The 3-bit arithmetic wraps on its own, so 7+1 gives 0 and 0-1 gives 7.
  function automatic logic [COUNT_W-1:0] next_expected(input logic [COUNT_W-1:0] prev,
                                                       input logic               up);
    return up ? prev + 3'd1 : prev - 3'd1;
  endfunction

endpackage

// File: rtl/count_step_checker_run_counter.sv
// Saturating run-length counter; term flags that this increment reaches LIMIT.
module run_counter
  import count_chk_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic term
);

  logic [RUN_W-1:0] cnt_q;
  logic [RUN_W-1:0] cnt_d;

  assign term = inc && (cnt_q >= RUN_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_step_checker.sv
// Checks that a 3-bit up/down counter steps by one each clock.
// Define COUNT_STEP_CHECKER_WRAP_CNT_EN to add the saturating wrap_cnt output.
module count_step_checker
  import count_chk_pkg::*;
#(
  parameter int ERR_LIMIT = 3,
  parameter int REACQ_LEN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  mode,
  input  logic [COUNT_W-1:0]    count,
  output logic                  step_err,
  output logic                  err_sticky,
  output logic                  wrap,
`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
`endif
  output logic                  locked
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] prev_count_q;
  logic               prev_mode_q;
  logic               step_err_q, step_err_d;
  logic               err_sticky_q;
  logic               wrap_q, wrap_d;
  logic               locked_q;

  logic [COUNT_W-1:0] expected;
  logic               good;
  logic               bad_inc, bad_clr, bad_term;
  logic               good_inc, good_clr, good_term;

  assign expected = next_expected(prev_count_q, prev_mode_q);
  assign good     = (count == expected);

  // Run counters only live in their own state and restart once they fire.
  assign bad_inc  = (state_q == TRACK) && !good && !clr;
  assign bad_clr  = clr || (state_q != TRACK) || good || bad_term;
  assign good_inc = (state_q == LOST) && good && !clr;
  assign good_clr = clr || (state_q != LOST) || !good || good_term;

  run_counter #(.LIMIT(ERR_LIMIT)) u_bad_run (
    .clk   (clk),
    .reset (reset),
    .inc   (bad_inc),
    .clr   (bad_clr),
    .term  (bad_term)
  );

  run_counter #(.LIMIT(REACQ_LEN)) u_good_run (
    .clk   (clk),
    .reset (reset),
    .inc   (good_inc),
    .clr   (good_clr),
    .term  (good_term)
  );

  always_comb begin
    state_d    = state_q;
    step_err_d = 1'b0;
    wrap_d     = 1'b0;
    unique case (state_q)
      SYNC: state_d = TRACK;
      TRACK: begin
        if (!good) begin
          step_err_d = 1'b1;
          if (bad_term) state_d = LOST;
        end else begin
          wrap_d = prev_mode_q ? (prev_count_q == '1) : (prev_count_q == '0);
        end
      end
      LOST: begin
        if (good_term) state_d = TRACK;
      end
      default: state_d = SYNC;
    endcase
    if (clr) begin
      state_d    = SYNC;
      step_err_d = 1'b0;
      wrap_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      prev_count_q <= '0;
      prev_mode_q  <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= count;
      prev_mode_q  <= mode;
      step_err_q   <= step_err_d;
      err_sticky_q <= clr ? 1'b0 : (err_sticky_q | step_err_d);
      wrap_q       <= wrap_d;
      locked_q     <= (state_d == TRACK);
    end
  end

  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign wrap       = wrap_q;
  assign locked     = locked_q;

`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_cnt_q <= '0;
    end else if (clr) begin
      wrap_cnt_q <= '0;
    end else if (wrap_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_count_step_checker.sv
// Table-driven bench for count_step_checker with an expected-result queue.
module tb_count_step_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] count = 3'd0;
  logic       step_err, err_sticky, wrap, locked;
`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
  logic [7:0] wrap_cnt;
`endif

  typedef struct {
    logic       clr;
    logic       mode;
    logic [2:0] count;
    logic       se;
    logic       st;
    logic       wr;
    logic       lk;
    int         wc;
  } vec_t;

  typedef struct {
    logic se;
    logic st;
    logic wr;
    logic lk;
    int   wc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  count_step_checker dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .mode       (mode),
    .count      (count),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .wrap       (wrap),
`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
    .wrap_cnt   (wrap_cnt),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic c, input logic m, input logic [2:0] n,
                        input logic se, input logic st, input logic wr,
                        input logic lk, input int wc);
    vec_t v;
    v.clr = c; v.mode = m; v.count = n;
    v.se = se; v.st = st; v.wr = wr; v.lk = lk; v.wc = wc;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_step_err"}, int'(step_err), int'(e.se));
    cmp({tag, "_err_sticky"}, int'(err_sticky), int'(e.st));
    cmp({tag, "_wrap"}, int'(wrap), int'(e.wr));
    cmp({tag, "_locked"}, int'(locked), int'(e.lk));
`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
    cmp({tag, "_wrap_cnt"}, int'(wrap_cnt), e.wc);
`endif
  endtask

  // Drive one sample, queue its expected outcome, and check one cycle later.
  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    clr   = v.clr;
    mode  = v.mode;
    count = v.count;
    e.se = v.se; e.st = v.st; e.wr = v.wr; e.lk = v.lk; e.wc = v.wc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vec_t v;

    // Up-count through a wrap; first sample only baselines.
    addVec(0, 1, 3'd0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++) addVec(0, 1, 3'(i), 0, 0, 0, 1, 0);
    addVec(0, 1, 3'd0, 0, 0, 1, 1, 1);
    addVec(0, 1, 3'd1, 0, 0, 0, 1, 1);
    // Down-count through a wrap.
    addVec(0, 0, 3'd2, 0, 0, 0, 1, 1);
    addVec(0, 0, 3'd1, 0, 0, 0, 1, 1);
    addVec(0, 0, 3'd0, 0, 0, 0, 1, 1);
    addVec(0, 0, 3'd7, 0, 0, 1, 1, 2);
    addVec(0, 0, 3'd6, 0, 0, 0, 1, 2);
    // Mode toggles mid-stream.
    addVec(0, 0, 3'd5, 0, 0, 0, 1, 2);
    addVec(0, 0, 3'd4, 0, 0, 0, 1, 2);
    addVec(0, 1, 3'd3, 0, 0, 0, 1, 2);
    addVec(0, 0, 3'd4, 0, 0, 0, 1, 2);
    addVec(0, 0, 3'd3, 0, 0, 0, 1, 2);
    addVec(0, 0, 3'd2, 0, 0, 0, 1, 2);
    // Single bad step 3 -> 5.
    addVec(0, 1, 3'd1, 0, 0, 0, 1, 2);
    addVec(0, 1, 3'd2, 0, 0, 0, 1, 2);
    addVec(0, 1, 3'd3, 0, 0, 0, 1, 2);
    addVec(0, 1, 3'd5, 1, 1, 0, 1, 2);
    addVec(0, 1, 3'd6, 0, 1, 0, 1, 2);
    // Three bad steps into LOST, then mixed steps until reacquired.
    addVec(0, 1, 3'd0, 1, 1, 0, 1, 2);
    addVec(0, 1, 3'd3, 1, 1, 0, 1, 2);
    addVec(0, 1, 3'd6, 1, 1, 0, 0, 2);
    addVec(0, 1, 3'd2, 0, 1, 0, 0, 2);
    addVec(0, 1, 3'd3, 0, 1, 0, 0, 2);
    addVec(0, 1, 3'd5, 0, 1, 0, 0, 2);
    addVec(0, 1, 3'd6, 0, 1, 0, 0, 2);
    addVec(0, 1, 3'd7, 0, 1, 0, 1, 2);
    addVec(0, 1, 3'd0, 0, 1, 1, 1, 3);
    // clr together with a bad step.
    addVec(1, 1, 3'd5, 0, 0, 0, 0, 0);
    addVec(0, 1, 3'd2, 0, 0, 0, 1, 0);
    addVec(0, 1, 3'd3, 0, 0, 0, 1, 0);
    addVec(0, 1, 3'd7, 1, 1, 0, 1, 0);
    addVec(0, 1, 3'd0, 0, 1, 1, 1, 1);

    $display("[TB] starting, %0d table vectors", vecs.size());
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_step_err", int'(step_err), 0);
    cmp("reset_err_sticky", int'(err_sticky), 0);
    cmp("reset_wrap", int'(wrap), 0);
    cmp("reset_locked", int'(locked), 0);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset between edges while outputs are non-zero.
    #2;
    reset = 1'b1;
    #1;
    cmp("async_rst_step_err", int'(step_err), 0);
    cmp("async_rst_err_sticky", int'(err_sticky), 0);
    cmp("async_rst_wrap", int'(wrap), 0);
    cmp("async_rst_locked", int'(locked), 0);
`ifdef COUNT_STEP_CHECKER_WRAP_CNT_EN
    cmp("async_rst_wrap_cnt", int'(wrap_cnt), 0);
`endif
    #1;
    reset = 1'b0;

    v.clr = 0; v.mode = 1; v.count = 3'd6;
    v.se = 0; v.st = 0; v.wr = 0; v.lk = 1; v.wc = 0;
    applyStimulus(v, "post_rst_baseline");
    v.count = 3'd7;
    applyStimulus(v, "post_rst_good");
    v.count = 3'd0; v.wr = 1; v.wc = 1;
    applyStimulus(v, "post_rst_wrap");
    v.count = 3'd4; v.wr = 0; v.se = 1; v.st = 1;
    applyStimulus(v, "post_rst_bad");

    cmp("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/count_step_checker.md
COUNT_STEP_CHECKER -- requirements
Module: count_step_checker

Interface
REQ-001 Parameter ERR_LIMIT, default 3, is the number of consecutive bad steps that moves TRACK to LOST (legal range 1..15).
REQ-002 Parameter REACQ_LEN, default 2, is the number of consecutive good steps that moves LOST back to TRACK (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 clr  input  1  synchronous clear: drops err_sticky and returns the FSM to SYNC.
REQ-006 mode  input  1  direction commanded to the upstream 3-bit counter; 1 = up, 0 = down.
REQ-007 count  input  3  counter value; one new value is sampled every clk.
REQ-008 step_err  output  1  one-cycle pulse: the sampled count is not the expected successor.
REQ-009 err_sticky  output  1  set by any step_err; held until reset or clr.
REQ-010 wrap  output  1  one-cycle pulse on a legal wrap: up 7->0 or down 0->7.
REQ-011 locked  output  1  high while the FSM is in TRACK.
REQ-012 wrap_cnt  output  8  saturating count of wrap pulses (present only under the macro; see Configuration).

Function
REQ-013 Each edge registers prev_count <= count and prev_mode <= mode.
REQ-014 Expected value = prev_count + 1 mod 8 if prev_mode = 1, else prev_count - 1 mod 8; the arithmetic is 3-bit and wraps naturally.
REQ-015 A step is good when count == expected; otherwise it is bad.
REQ-016 FSM states are SYNC, TRACK and LOST.
REQ-017 SYNC: no comparison, no step_err; after one sample the FSM goes to TRACK.
REQ-018 TRACK: each bad step pulses step_err and increments bad_run; each good step clears bad_run.
REQ-019 TRACK -> LOST when bad_run reaches ERR_LIMIT; the step_err pulse for that step is still emitted.
REQ-020 LOST: step_err is suppressed and good_run counts consecutive good steps; a bad step clears good_run.
REQ-021 LOST -> TRACK when good_run reaches REACQ_LEN; bad_run is cleared on entry to TRACK.
REQ-022 All outputs are registered, with one cycle of latency: a pulse is high during the cycle after the edge that sampled the offending or wrapping count.
REQ-023 wrap is evaluated only in TRACK and only on good steps.
REQ-024 A mode change is legal at any cycle; the expected value always uses the mode registered with the previous count.
REQ-025 If clr and a bad step coincide, clr wins: no step_err, err_sticky = 0, next state = SYNC.
REQ-026 If a step_err pulse and err_sticky coincide, err_sticky is set in the same cycle as the pulse.

Reset
REQ-027 On reset assertion: state = SYNC; prev_count = 0, prev_mode = 0; bad_run and good_run = 0; step_err, err_sticky, wrap and locked = 0; wrap_cnt = 0.
REQ-028 Reset asserted mid-sequence takes effect without waiting for clk; after release, the first sampled count only re-baselines.

Configuration
REQ-029 Macro COUNT_STEP_CHECKER_WRAP_CNT_EN governs the wrap counter.
REQ-030 With the macro defined: port wrap_cnt exists, increments on each wrap pulse, saturates at 255 and is cleared by reset or clr.
REQ-031 Without the macro: the wrap_cnt port and its register are absent; all other behaviour is identical.

Structure
REQ-032 Shared package count_chk_pkg holds the FSM state enum (SYNC, TRACK, LOST), COUNT_W = 3 and WRAP_CNT_W = 8.
REQ-033 One sub-module, run_counter, is used for bad_run and good_run: a 4-bit saturating counter with inc, clr and a terminal-reached output.

Verification
REQ-034 Reset release, mode = 1, counts 0,1,...,7,0,1 -> locked = 1 from the second sample, no step_err, exactly one wrap pulse (7->0), wrap_cnt = 1 when enabled.
REQ-035 mode = 0, counts 2,1,0,7,6 -> exactly one wrap pulse (0->7), no step_err.
REQ-036 In TRACK, count jumps 3 -> 5 with mode = 1 -> step_err pulses once, err_sticky = 1, locked stays 1.
REQ-037 Three consecutive bad steps (ERR_LIMIT = 3) -> three step_err pulses and locked = 0; then two good steps -> locked = 1, with no step_err while in LOST.
REQ-038 mode toggles 1->0 at count = 4 (sequence 3,4,3,2) -> no step_err.
REQ-039 Reset pulse between clock edges mid-count -> all outputs 0 immediately; clr asserted together with a bad step -> no step_err, err_sticky = 0, FSM in SYNC.
